// File: rtl/display_scheduler_if.sv
// display_scheduler_if: requester-side content/request bundle and the
// scan/grant pins driven back by the scheduler.
interface display_scheduler_if;
   logic [1:0]  req;
   logic [63:0] frame0;
   logic [63:0] frame1;
   logic [47:0] seg0;
   logic [47:0] seg1;
   logic [1:0]  gnt;
   logic        busy;
   logic [7:0]  row;
   logic [7:0]  col;
   logic [7:0]  digit_seg;
   logic [7:0]  digit_cath;

   modport master (
      output req, frame0, frame1, seg0, seg1,
      input  gnt, busy, row, col, digit_seg, digit_cath
   );

   modport slave (
      input  req, frame0, frame1, seg0, seg1,
      output gnt, busy, row, col, digit_seg, digit_cath
   );
endinterface

// File: rtl/display_scheduler.sv
// display_scheduler: owns the 8x8 lattice and 6-digit seven-segment bank.
// Runs a blink self-test after reset, then round-robins the display between
// two requesters with a minimum hold time. Row and digit scan run always.
// Optional macro STARTUP_TEST_EN builds the self-test; without it reset
// goes straight to IDLE and busy stays 0.
// All pins are registered from next-state values, so a pin changes on the
// same edge as the state/index that drives it.
module display_scheduler #(
   parameter int SCAN_DIV    = 50000,
   parameter int BLINK_DIV   = 12500000,
   parameter int BLINK_COUNT = 6,
   parameter int HOLD_TICKS  = 4
) (
   input  logic               clk,
   input  logic               rst,
   display_scheduler_if.slave bus
);
   localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);

   typedef enum logic [1:0] {STARTUP, IDLE, SERVE0, SERVE1} state_t;

`ifdef STARTUP_TEST_EN
   localparam int     TW        = $clog2(BLINK_COUNT + 1);
   localparam state_t RST_STATE = STARTUP;
   localparam logic   RST_BUSY  = 1'b1;
`else
   localparam state_t RST_STATE = IDLE;
   localparam logic   RST_BUSY  = 1'b0;
`endif

   logic [SW-1:0] scan_cnt_q;
   logic [BW-1:0] blink_cnt_q;
   logic          scan_tick, blink_tick;
   logic [2:0]    r_q, r_d, d_q, d_d;
   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          last_q, last_d;   // 1: requester 1 was served last
`ifdef STARTUP_TEST_EN
   logic          phase_q, phase_d; // 1: lamps lit
   logic [TW-1:0] tcnt_q, tcnt_d;   // blink ticks seen during self-test
`endif
   logic [7:0]    row_q, row_d, col_q, col_d, seg_q, seg_d, cath_q, cath_d;
   logic [1:0]    gnt_q, gnt_d;
   logic          busy_q, busy_d;

   assign scan_tick  = (scan_cnt_q  == SW'(SCAN_DIV - 1));
   assign blink_tick = (blink_cnt_q == BW'(BLINK_DIV - 1));

   // Free-running dividers and the scan indices (digit index skips 6 and 7)
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_q  <= '0;
         blink_cnt_q <= '0;
         r_q         <= '0;
         d_q         <= '0;
      end else begin
         scan_cnt_q  <= scan_tick  ? '0 : scan_cnt_q  + SW'(1);
         blink_cnt_q <= blink_tick ? '0 : blink_cnt_q + BW'(1);
         r_q         <= r_d;
         d_q         <= d_d;
      end
   end

   // Next scan indices
   always_comb begin
      r_d = r_q;
      d_d = d_q;
      if (scan_tick) begin
         r_d = r_q + 3'd1;
         d_d = (d_q == 3'd5) ? 3'd0 : d_q + 3'd1;
      end
   end

   // Arbitration state, hold counter and round-robin memory
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RST_STATE;
         hold_q  <= '0;
         last_q  <= 1'b1;
`ifdef STARTUP_TEST_EN
         phase_q <= 1'b1;
         tcnt_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
`ifdef STARTUP_TEST_EN
         phase_q <= phase_d;
         tcnt_q  <= tcnt_d;
`endif
      end
   end

   // Next state: self-test blink, idle arbitration, hold-gated release/switch
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      hold_d  = (blink_tick && (hold_q < HW'(HOLD_TICKS))) ? hold_q + HW'(1) : hold_q;
`ifdef STARTUP_TEST_EN
      phase_d = phase_q;
      tcnt_d  = tcnt_q;
`endif
      case (state_q)
`ifdef STARTUP_TEST_EN
         STARTUP: begin
            if (blink_tick) begin
               phase_d = ~phase_q;
               if (tcnt_q == TW'(BLINK_COUNT - 1)) state_d = IDLE;
               else                                tcnt_d  = tcnt_q + TW'(1);
            end
         end
`endif
         IDLE: begin
            if (bus.req[0] && (!bus.req[1] || last_q)) state_d = SERVE0;
            else if (bus.req[1])                       state_d = SERVE1;
         end
         SERVE0: begin
            if (hold_q >= HW'(HOLD_TICKS)) begin
               if (bus.req[1])       state_d = SERVE1;
               else if (!bus.req[0]) state_d = IDLE;
            end
         end
         SERVE1: begin
            if (hold_q >= HW'(HOLD_TICKS)) begin
               if (bus.req[0])       state_d = SERVE0;
               else if (!bus.req[1]) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Any new grant (from IDLE or a direct switch) restarts the hold time
      if ((state_d == SERVE0 || state_d == SERVE1) && (state_d != state_q)) begin
         hold_d = '0;
         last_d = (state_d == SERVE1);
      end
   end

   // Pin values for the upcoming cycle; frames are sampled live
   always_comb begin
      row_d  = ~(8'd1 << r_d);
      cath_d = {2'b11, ~(6'd1 << d_d)};
      col_d  = '0;
      seg_d  = '0;
      gnt_d  = '0;
      busy_d = 1'b0;
      case (state_d)
`ifdef STARTUP_TEST_EN
         STARTUP: begin
            busy_d = 1'b1;
            col_d  = {8{phase_d}};
            seg_d  = {8{phase_d}};
         end
`endif
         SERVE0: begin
            gnt_d = 2'b01;
            col_d = bus.frame0[{r_d, 3'b000} +: 8];
            seg_d = bus.seg0[{d_d, 3'b000} +: 8];
         end
         SERVE1: begin
            gnt_d = 2'b10;
            col_d = bus.frame1[{r_d, 3'b000} +: 8];
            seg_d = bus.seg1[{d_d, 3'b000} +: 8];
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q  <= 8'hFE;
         col_q  <= 8'h00;
         seg_q  <= 8'h00;
         cath_q <= 8'hFE;
         gnt_q  <= 2'b00;
         busy_q <= RST_BUSY;
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         seg_q  <= seg_d;
         cath_q <= cath_d;
         gnt_q  <= gnt_d;
         busy_q <= busy_d;
      end
   end

   assign bus.row        = row_q;
   assign bus.col        = col_q;
   assign bus.digit_seg  = seg_q;
   assign bus.digit_cath = cath_q;
   assign bus.gnt        = gnt_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed checks of self-test, scan, grant, hold,
// round-robin switching and reset-mid-grant. Cycle k = k-th clk edge after
// the reset edge; outputs are sampled 1 time unit after that edge.
module tb_display_scheduler;
   localparam int SCAN = 4, BLINK = 10, BCNT = 6, HOLD = 2;
`ifdef STARTUP_TEST_EN
   localparam int   ST    = 60;   // BCNT * BLINK cycles of self-test
   localparam logic BUSY0 = 1'b1;
`else
   localparam int   ST    = 0;
   localparam logic BUSY0 = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   display_scheduler_if dif ();

   display_scheduler #(
      .SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .BLINK_COUNT(BCNT), .HOLD_TICKS(HOLD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(dif)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_row(int k);
      int rr;
      rr = (k / SCAN) % 8;
      return ~(8'd1 << rr);
   endfunction

   function automatic logic [7:0] exp_cath(int k);
      int dd;
      dd = (k / SCAN) % 6;
      return {2'b11, ~(6'd1 << dd)};
   endfunction

   function automatic logic [7:0] pick64(logic [63:0] v, int k);
      return v[8*((k / SCAN) % 8) +: 8];
   endfunction

   function automatic logic [7:0] pick48(logic [47:0] v, int k);
      return v[8*((k / SCAN) % 6) +: 8];
   endfunction

   task automatic go(int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset;
      dif.req = 2'b00;
      do_reset();
      n_chk++; if (dif.row !== 8'hFE) $display("FAIL rst_row got %h exp FE", dif.row); else n_pass++;
      n_chk++; if (dif.col !== 8'h00) $display("FAIL rst_col got %h exp 00", dif.col); else n_pass++;
      n_chk++; if (dif.digit_seg !== 8'h00) $display("FAIL rst_seg got %h exp 00", dif.digit_seg); else n_pass++;
      n_chk++; if (dif.digit_cath !== 8'hFE) $display("FAIL rst_cath got %h exp FE", dif.digit_cath); else n_pass++;
      n_chk++; if (dif.gnt !== 2'b00) $display("FAIL rst_gnt got %b exp 00", dif.gnt); else n_pass++;
      n_chk++; if (dif.busy !== BUSY0) $display("FAIL rst_busy got %b exp %b", dif.busy, BUSY0); else n_pass++;
   endtask

`ifdef STARTUP_TEST_EN
   task automatic test_startup;
      dif.req = 2'b00;
      do_reset();
      go(1);
      n_chk++; if (dif.col !== 8'hFF || dif.digit_seg !== 8'hFF) $display("FAIL st_lit1 got %h/%h exp FF/FF", dif.col, dif.digit_seg); else n_pass++;
      n_chk++; if (dif.busy !== 1'b1) $display("FAIL st_busy1 got %b exp 1", dif.busy); else n_pass++;
      go(9);
      n_chk++; if (dif.col !== 8'hFF) $display("FAIL st_lit9 got %h exp FF", dif.col); else n_pass++;
      go(10);
      n_chk++; if (dif.col !== 8'h00 || dif.digit_seg !== 8'h00) $display("FAIL st_dark10 got %h/%h exp 00/00", dif.col, dif.digit_seg); else n_pass++;
      go(19);
      n_chk++; if (dif.col !== 8'h00) $display("FAIL st_dark19 got %h exp 00", dif.col); else n_pass++;
      go(20);
      n_chk++; if (dif.col !== 8'hFF) $display("FAIL st_lit20 got %h exp FF", dif.col); else n_pass++;
      go(49);
      n_chk++; if (dif.col !== 8'hFF) $display("FAIL st_lit49 got %h exp FF", dif.col); else n_pass++;
      go(50);
      n_chk++; if (dif.col !== 8'h00) $display("FAIL st_dark50 got %h exp 00", dif.col); else n_pass++;
      go(59);
      n_chk++; if (dif.busy !== 1'b1) $display("FAIL st_busy59 got %b exp 1", dif.busy); else n_pass++;
      go(60);
      n_chk++; if (dif.busy !== 1'b0) $display("FAIL st_busy60 got %b exp 0", dif.busy); else n_pass++;
      n_chk++; if (dif.col !== 8'h00 || dif.gnt !== 2'b00) $display("FAIL st_exit col/gnt got %h/%b exp 00/00", dif.col, dif.gnt); else n_pass++;
   endtask
`else
   task automatic test_no_startup;
      dif.req = 2'b00;
      do_reset();
      go(1);
      n_chk++; if (dif.busy !== 1'b0) $display("FAIL ns_busy1 got %b exp 0", dif.busy); else n_pass++;
      n_chk++; if (dif.col !== 8'h00) $display("FAIL ns_col1 got %h exp 00", dif.col); else n_pass++;
      go(30);
      n_chk++; if (dif.busy !== 1'b0) $display("FAIL ns_busy30 got %b exp 0", dif.busy); else n_pass++;
   endtask
`endif

   task automatic test_scan;
      dif.req = 2'b00;
      do_reset();
      for (int k = 1; k <= ST + 30; k++) begin
         go(k);
         n_chk++; if (dif.row !== exp_row(k)) $display("FAIL scan_row@%0d got %h exp %h", k, dif.row, exp_row(k)); else n_pass++;
         n_chk++; if (dif.digit_cath !== exp_cath(k)) $display("FAIL scan_cath@%0d got %h exp %h", k, dif.digit_cath, exp_cath(k)); else n_pass++;
      end
      n_chk++; if (dif.col !== 8'h00 || dif.digit_seg !== 8'h00) $display("FAIL idle_data got %h/%h exp 00/00", dif.col, dif.digit_seg); else n_pass++;
   endtask

   task automatic test_grant;
      dif.req = 2'b01;
      do_reset();
`ifdef STARTUP_TEST_EN
      go(30);
      n_chk++; if (dif.gnt !== 2'b00) $display("FAIL gnt_in_selftest got %b exp 00", dif.gnt); else n_pass++;
`endif
      go(ST);
      n_chk++; if (dif.gnt !== 2'b00) $display("FAIL gnt_pre got %b exp 00", dif.gnt); else n_pass++;
      go(ST + 1);
      n_chk++; if (dif.gnt !== 2'b01) $display("FAIL gnt_rise got %b exp 01", dif.gnt); else n_pass++;
      n_chk++; if (dif.col !== pick64(dif.frame0, ST + 1)) $display("FAIL gnt_col got %h exp %h", dif.col, pick64(dif.frame0, ST + 1)); else n_pass++;
      n_chk++; if (dif.digit_seg !== pick48(dif.seg0, ST + 1)) $display("FAIL gnt_seg got %h exp %h", dif.digit_seg, pick48(dif.seg0, ST + 1)); else n_pass++;
      go(ST + 4);
      n_chk++; if (dif.col !== pick64(dif.frame0, ST + 4)) $display("FAIL gnt_col_diag got %h exp %h", dif.col, pick64(dif.frame0, ST + 4)); else n_pass++;
   endtask

   task automatic test_hold_release;
      dif.req = 2'b00;   // dropped 3 cycles after grant
      go(ST + 8);
      n_chk++; if (dif.gnt !== 2'b01) $display("FAIL hold_keep got %b exp 01", dif.gnt); else n_pass++;
      n_chk++; if (dif.col !== pick64(dif.frame0, ST + 8)) $display("FAIL hold_stale got %h exp %h", dif.col, pick64(dif.frame0, ST + 8)); else n_pass++;
      go(ST + 20);
      n_chk++; if (dif.gnt !== 2'b01) $display("FAIL hold_last got %b exp 01", dif.gnt); else n_pass++;
      go(ST + 21);
      n_chk++; if (dif.gnt !== 2'b00) $display("FAIL release_gnt got %b exp 00", dif.gnt); else n_pass++;
      n_chk++; if (dif.col !== 8'h00 || dif.digit_seg !== 8'h00) $display("FAIL release_data got %h/%h exp 00/00", dif.col, dif.digit_seg); else n_pass++;
   endtask

   task automatic test_back_to_back;
      dif.req = 2'b11;
      do_reset();
      go(ST + 1);
      n_chk++; if (dif.gnt !== 2'b01) $display("FAIL rr_first got %b exp 01", dif.gnt); else n_pass++;
      go(ST + 20);
      n_chk++; if (dif.gnt !== 2'b01) $display("FAIL rr_hold0 got %b exp 01", dif.gnt); else n_pass++;
      go(ST + 21);
      n_chk++; if (dif.gnt !== 2'b10) $display("FAIL rr_switch1 got %b exp 10", dif.gnt); else n_pass++;
      n_chk++; if (dif.col !== pick64(dif.frame1, ST + 21)) $display("FAIL rr_col1 got %h exp %h", dif.col, pick64(dif.frame1, ST + 21)); else n_pass++;
      n_chk++; if (dif.digit_seg !== pick48(dif.seg1, ST + 21)) $display("FAIL rr_seg1 got %h exp %h", dif.digit_seg, pick48(dif.seg1, ST + 21)); else n_pass++;
      go(ST + 40);
      n_chk++; if (dif.gnt !== 2'b10) $display("FAIL rr_hold1 got %b exp 10", dif.gnt); else n_pass++;
      go(ST + 41);
      n_chk++; if (dif.gnt !== 2'b01) $display("FAIL rr_switch0 got %b exp 01", dif.gnt); else n_pass++;
      go(ST + 61);
      n_chk++; if (dif.gnt !== 2'b10) $display("FAIL rr_switch1b got %b exp 10", dif.gnt); else n_pass++;
   endtask

   task automatic test_rst_mid_grant;
      go(ST + 65);   // SERVE1, requests still 11
      do_reset();
      n_chk++; if (dif.gnt !== 2'b00) $display("FAIL mid_gnt got %b exp 00", dif.gnt); else n_pass++;
      n_chk++; if (dif.busy !== BUSY0) $display("FAIL mid_busy got %b exp %b", dif.busy, BUSY0); else n_pass++;
      n_chk++; if (dif.row !== 8'hFE || dif.digit_cath !== 8'hFE) $display("FAIL mid_scan got %h/%h exp FE/FE", dif.row, dif.digit_cath); else n_pass++;
      n_chk++; if (dif.col !== 8'h00 || dif.digit_seg !== 8'h00) $display("FAIL mid_data got %h/%h exp 00/00", dif.col, dif.digit_seg); else n_pass++;
`ifdef STARTUP_TEST_EN
      go(1);
      n_chk++; if (dif.col !== 8'hFF || dif.busy !== 1'b1) $display("FAIL mid_selftest got %h/%b exp FF/1", dif.col, dif.busy); else n_pass++;
`endif
      go(ST + 1);
      n_chk++; if (dif.gnt !== 2'b01) $display("FAIL mid_regrant got %b exp 01", dif.gnt); else n_pass++;
   endtask

   task automatic test_req1_only;
      dif.req = 2'b10;
      do_reset();
      go(ST + 1);
      n_chk++; if (dif.gnt !== 2'b10) $display("FAIL r1_gnt got %b exp 10", dif.gnt); else n_pass++;
      n_chk++; if (dif.busy !== 1'b0) $display("FAIL r1_busy got %b exp 0", dif.busy); else n_pass++;
      n_chk++; if (dif.col !== pick64(dif.frame1, ST + 1)) $display("FAIL r1_col got %h exp %h", dif.col, pick64(dif.frame1, ST + 1)); else n_pass++;
   endtask

   initial begin
      dif.req    = 2'b00;
      dif.frame0 = 64'h0102040810204080;
      dif.frame1 = 64'h8844221100FF7E3C;
      dif.seg0   = 48'h665544332211;
      dif.seg1   = 48'hCCBBAA998877;
      test_reset();
`ifdef STARTUP_TEST_EN
      test_startup();
`else
      test_no_startup();
`endif
      test_scan();
      test_grant();
      test_hold_release();
      test_back_to_back();
      test_rst_mid_grant();
      test_req1_only();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
